div_issue_ctrl: RTL

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl_pkg.sv | 20 ++
 rtl/div_issue_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg
// Shared CPU definitions used by the divider issue controller:
//   - one-hot state encodings of the issue FSM
//   - bit positions inside the 2-bit divide opcode (in_op)
package div_issue_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  // One-hot FSM encodings
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_BUSY  = 4'b0010;
  localparam logic [3:0] ST_DRAIN = 4'b0100;
  localparam logic [3:0] ST_HOLD  = 4'b1000;

  // in_op bit positions: bit1 = unsigned(1)/signed(0), bit0 = mod(1)/div(0)
  localparam int OP_UNSIGNED_BIT = 1;
  localparam int OP_MOD_BIT      = 0;

endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// Issue/retire controller that sits between ID/EXE and a multi-cycle divider.
// It latches one divide/modulo op, holds the request to the divider until the
// divider pulses div_done, and presents the result to MEM until accepted.
// A flush while the divider is running cannot abort the divider, so the
// controller drains the pending completion and discards it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream op handshake
//   in_src1/in_src2          dividend / divisor
//   in_op                    bit1 unsigned, bit0 modulo
//   in_dest                  destination tag
//   flush                    kills the in-flight op
//   out_valid/out_ready      result handshake toward MEM
//   out_result/out_dest      captured result and its tag
//   busy                     controller not idle
//   div_src1/div_src2        latched operands to divider
//   div_is_s/div_is_u        divider request, signed / unsigned
//   div_or_mod               1 = quotient, 0 = remainder
//   div_result/div_done      divider result and one-cycle completion pulse
//
// state | meaning
// IDLE  | ready to accept an op
// BUSY  | request held to divider, waiting for div_done
// DRAIN | flushed while divider running; wait for div_done and discard
// HOLD  | result presented on out_*, waiting for out_ready
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_dest,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        busy,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  output logic        div_is_s,
  output logic        div_is_u,
  output logic        div_or_mod,
  input  logic [31:0] div_result,
  input  logic        div_done
);

  logic [3:0]  state_q, state_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] result_q, result_d;

  logic accept;
  logic req_active;

  assign in_ready   = (state_q == ST_IDLE);
  assign accept     = in_valid & in_ready & ~flush;
  assign req_active = (state_q == ST_BUSY) | (state_q == ST_DRAIN);

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    op_d     = op_q;
    dest_d   = dest_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src1_d  = in_src1;
          src2_d  = in_src2;
          op_d    = in_op;
          dest_d  = in_dest;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_done && !flush) begin
          result_d = div_result;
          state_d  = ST_HOLD;
        end else if (div_done) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // flush is irrelevant here; the pending completion is discarded anyway
        if (div_done) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_HOLD);
  assign out_result = result_q;
  assign out_dest   = dest_q;
  assign div_src1   = src1_q;
  assign div_src2   = src2_q;
  assign div_is_s   = req_active & ~op_q[OP_UNSIGNED_BIT];
  assign div_is_u   = req_active &  op_q[OP_UNSIGNED_BIT];
  assign div_or_mod = ~op_q[OP_MOD_BIT];

endmodule
